ysyx_22040088_lsu: RTL
======================

# ysyx_22040088_lsu

Load/store unit for the NPC core. It is the responder to the decoder's memory control outputs (`mem_ena`, `mem_wen`, `mem_mask`, `sel_memdata`). It accepts one access from the execute stage and converts it into a single transaction on a 64-bit valid/ready data-memory bus. For stores it positions data and byte strobes; for loads it returns extracted, sign- or zero-extended read data together with a completion pulse.

## Interface
- No parameters; widths are fixed by `ysyx_22040088_pkg` (XLEN=64).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `lsu_valid` in 1: access request from EX; the access is `mem_ena & lsu_valid`.
- `lsu_ready` out 1: LSU idle, can accept an access this cycle.
- `mem_ena` in 1: access enable from decoder.
- `mem_wen` in 1: 1 = store, 0 = load.
- `mem_mask` in 4: one-hot size: 0001 = dword, 0010 = word, 0100 = half, 1000 = byte.
- `sel_memdata` in 2: load extension: 01 = sign, 10 = zero.
- `addr` in 64: byte address (ALU result).
- `wdata` in 64: store data, right-aligned.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_rdata` out 64: extended load data, valid with `lsu_done`; 0 for stores.
- `lsu_err` out 1: misaligned access, valid with `lsu_done` (only with the macro below).
- `bus_req_valid` out 1, `bus_req_ready` in 1: request handshake.
- `bus_addr` out 64: `addr` with bits [2:0] cleared.
- `bus_wen` out 1, `bus_wdata` out 64, `bus_wstrb` out 8.
- `bus_resp_valid` in 1, `bus_resp_ready` out 1, `bus_rdata` in 64: response (sent for stores too).

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - `lsu_ready` = 1.
  - When `lsu_valid & mem_ena`, latch addr, size, wen, ext and the aligned wdata/wstrb, then go to REQ.
  - `lsu_valid` with `mem_ena` = 0 is ignored.
- **REQ**
  - `bus_req_valid` = 1; request fields held stable until `bus_req_ready`, then go to RESP.
- **RESP**
  - `bus_resp_ready` = 1.
  - On `bus_resp_valid`, register the result, pulse `lsu_done` next cycle, and go to IDLE.
- **Size and byte offset**
  - Size bytes: 8/4/2/1 from `mem_mask`. Offset `off` = `addr[2:0]`.
  - `bus_wstrb` = (size ones) << `off`.
  - `bus_wdata` = `wdata` << (8·`off`).
- **Load extraction**
  - raw = `bus_rdata` >> (8·`off`), truncated to size.
  - `sel_memdata` = 10: zero-extend; any other value: sign-extend from the top bit of the size.
  - Dword loads are unaffected by extension.
- `mem_mask` = 0000 or not one-hot with `mem_ena` = 1: treated as dword.
- Accesses never split across an 8-byte boundary; see Configuration for misaligned handling.

## Timing
- Reset (async, `rst_n` low)
  - FSM goes to IDLE; `lsu_ready` = 1.
  - `lsu_done`, `lsu_err`, `bus_req_valid`, `bus_resp_ready`, `bus_wen` = 0; `lsu_rdata`, `bus_addr`, `bus_wdata`, `bus_wstrb` = 0.
  - Reset mid-transaction abandons it; the bus must tolerate a dropped request.
- Accept in cycle 0 → `bus_req_valid` in cycle 1.
- Zero-wait bus: ready in cycle 1, resp_valid in cycle 2 → `lsu_done` in cycle 3. Minimum latency is 3 cycles.
- Wait states on either handshake add cycles one-for-one.
- `lsu_done` coincides with IDLE. A new access is accepted in the same cycle as `lsu_done` (back-to-back).
- `lsu_rdata`/`lsu_err` hold their value until the next `lsu_done`.
- `bus_resp_valid` outside RESP is ignored.

## Configuration
- `YSYX_22040088_LSU_MISALIGN_EN` defined:
  - An access with `addr` not aligned to its size issues no bus transaction.
  - IDLE → `lsu_done` next cycle with `lsu_err` = 1 and `lsu_rdata` = 0.
- Undefined:
  - `lsu_err` is tied 0.
  - Offset low bits below the natural alignment are cleared: word uses `off & 4`, half uses `off & 6`, dword uses 0.
  - The access proceeds normally.

## Structure
- `ysyx_22040088_pkg`: XLEN, the `mem_mask` one-hot encodings, the `sel_memdata` encodings, and the LSU state enum.
- Sub-module `ysyx_22040088_lsu_align`: purely combinational. Computes wstrb/wdata shifting and load extraction/extension. Instantiated once; the FSM lives in the parent.

## Test plan
- sb: addr=0x8000_0003, wdata=0xAB, zero-wait bus → `bus_addr`=0x8000_0000, `bus_wstrb`=0x08, `bus_wdata`[31:24]=0xAB; `lsu_done` in cycle 3 with `lsu_rdata`=0.
- lw vs lwu: addr=0x…04, `bus_rdata`=0x8000_0001_xxxx_xxxx → lw gives 0xFFFF_FFFF_8000_0001; lwu (`sel_memdata`=10) gives 0x0000_0000_8000_0001.
- lb: addr offset 7, `bus_rdata`[63:56]=0x80 → `lsu_rdata`=0xFFFF_FFFF_FFFF_FF80.
- Wait states: `bus_req_ready` low 3 cycles, `bus_resp_valid` 2 cycles later → request fields stable throughout; `lsu_done` at cycle 3+3+2=8; exactly one done pulse.
- Back-to-back: a second ld accepted in the `lsu_done` cycle → second `bus_req_valid` the next cycle; `rst_n` pulsed low in RESP → all outputs 0 immediately, IDLE, no `lsu_done`.
- With the macro, lh at addr 0x…01 → no `bus_req_valid`, `lsu_done` and `lsu_err`=1 the next cycle. Without the macro → `bus_wstrb`/extract use offset 0.

Source files
------------

// File: rtl/ysyx_22040088_pkg.sv
// rtl/ysyx_22040088_pkg.sv - shared widths, encodings and state types for the NPC load/store unit
package ysyx_22040088_pkg;

   localparam int XLEN = 64;

   // mem_mask one-hot access sizes from the decoder
   localparam logic [3:0] MASK_D = 4'b0001;
   localparam logic [3:0] MASK_W = 4'b0010;
   localparam logic [3:0] MASK_H = 4'b0100;
   localparam logic [3:0] MASK_B = 4'b1000;

   // sel_memdata load extension kinds
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_ZERO = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_D = 2'd0,
      SZ_W = 2'd1,
      SZ_H = 2'd2,
      SZ_B = 2'd3
   } lsu_size_e;

   // Anything that is not a clean one-hot narrow size behaves as a dword
   function automatic lsu_size_e decode_size(input logic [3:0] mask);
      case (mask)
         MASK_W:  decode_size = SZ_W;
         MASK_H:  decode_size = SZ_H;
         MASK_B:  decode_size = SZ_B;
         default: decode_size = SZ_D;
      endcase
   endfunction

   // Offset bits that must be zero for a naturally aligned access of this size
   function automatic logic [2:0] align_bits(input lsu_size_e sz);
      case (sz)
         SZ_D:    align_bits = 3'b111;
         SZ_W:    align_bits = 3'b011;
         SZ_H:    align_bits = 3'b001;
         default: align_bits = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// rtl/ysyx_22040088_lsu_align.sv - combinational store lane placement and load extraction/extension
module ysyx_22040088_lsu_align
   import ysyx_22040088_pkg::*;
(
   input  logic [1:0]  st_size_i,
   input  logic [2:0]  st_off_i,
   input  logic [63:0] st_wdata_i,
   output logic [7:0]  st_wstrb_o,
   output logic [63:0] st_wdata_o,
   output logic        st_misalign_o,
   input  logic [1:0]  ld_size_i,
   input  logic [2:0]  ld_off_i,
   input  logic [1:0]  ld_ext_i,
   input  logic [63:0] ld_rdata_i,
   output logic [63:0] ld_data_o
);

   lsu_size_e   st_size;
   lsu_size_e   ld_size;
   logic [2:0]  st_off_eff;
   logic [2:0]  ld_off_eff;
   logic [7:0]  st_ones;
   logic [63:0] ld_raw;
   logic        ld_sext;

   assign st_size = lsu_size_e'(st_size_i);
   assign ld_size = lsu_size_e'(ld_size_i);

   // Sub-alignment offset bits are dropped so an access never crosses the dword
   assign st_off_eff = st_off_i & ~align_bits(st_size);
   assign ld_off_eff = ld_off_i & ~align_bits(ld_size);

   // Store side: byte strobes and data moved into the addressed lanes
   always_comb begin
      st_misalign_o = (st_off_i & align_bits(st_size)) != 3'b000;
      case (st_size)
         SZ_B:    st_ones = 8'h01;
         SZ_H:    st_ones = 8'h03;
         SZ_W:    st_ones = 8'h0F;
         default: st_ones = 8'hFF;
      endcase
      st_wstrb_o = st_ones << st_off_eff;
      st_wdata_o = st_wdata_i << {st_off_eff, 3'b000};
   end

   // Load side: shift the addressed lanes down, then sign- or zero-extend
   always_comb begin
      ld_raw  = ld_rdata_i >> {ld_off_eff, 3'b000};
      ld_sext = (ld_ext_i != EXT_ZERO);
      case (ld_size)
         SZ_B:    ld_data_o = {{56{ld_sext & ld_raw[7]}}, ld_raw[7:0]};
         SZ_H:    ld_data_o = {{48{ld_sext & ld_raw[15]}}, ld_raw[15:0]};
         SZ_W:    ld_data_o = {{32{ld_sext & ld_raw[31]}}, ld_raw[31:0]};
         default: ld_data_o = ld_raw;
      endcase
   end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// rtl/ysyx_22040088_lsu.sv - load/store unit FSM driving one valid/ready bus transaction per access (option: YSYX_22040088_LSU_MISALIGN_EN)
module ysyx_22040088_lsu
   import ysyx_22040088_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic        mem_ena,
   input  logic        mem_wen,
   input  logic [3:0]  mem_mask,
   input  logic [1:0]  sel_memdata,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        lsu_done,
   output logic [63:0] lsu_rdata,
   output logic        lsu_err,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [63:0] bus_addr,
   output logic        bus_wen,
   output logic [63:0] bus_wdata,
   output logic [7:0]  bus_wstrb,
   input  logic        bus_resp_valid,
   output logic        bus_resp_ready,
   input  logic [63:0] bus_rdata
);

   lsu_state_e  state_q, state_d;
   lsu_size_e   size_q;
   logic [2:0]  off_q;
   logic [1:0]  ext_q;
   logic        wen_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [7:0]  wstrb_q;
   logic        done_q;
   logic [63:0] rdata_q;

   logic        req_fire;
   logic        misalign;
   logic [7:0]  st_wstrb;
   logic [63:0] st_wdata;
   logic        st_misalign;
   logic [63:0] ld_data;

   assign req_fire = (state_q == LSU_IDLE) & lsu_valid & mem_ena;

   ysyx_22040088_lsu_align u_align (
      .st_size_i     (decode_size(mem_mask)),
      .st_off_i      (addr[2:0]),
      .st_wdata_i    (wdata),
      .st_wstrb_o    (st_wstrb),
      .st_wdata_o    (st_wdata),
      .st_misalign_o (st_misalign),
      .ld_size_i     (size_q),
      .ld_off_i      (off_q),
      .ld_ext_i      (ext_q),
      .ld_rdata_i    (bus_rdata),
      .ld_data_o     (ld_data)
   );

`ifdef YSYX_22040088_LSU_MISALIGN_EN
   logic err_q;
   assign misalign = st_misalign;
   assign lsu_err  = err_q;
`else
   logic unused_misalign;
   assign unused_misalign = st_misalign;
   assign misalign        = 1'b0;
   assign lsu_err         = 1'b0;
`endif

   // State register; reset abandons any in-flight access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LSU_IDLE;
      else        state_q <= state_d;
   end

   // Next state: misaligned accesses complete from IDLE without touching the bus
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: if (req_fire && !misalign) state_d = LSU_REQ;
         LSU_REQ:  if (bus_req_ready)         state_d = LSU_RESP;
         LSU_RESP: if (bus_resp_valid)        state_d = LSU_IDLE;
         default:                             state_d = LSU_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      lsu_ready      = (state_q == LSU_IDLE);
      bus_req_valid  = (state_q == LSU_REQ);
      bus_resp_ready = (state_q == LSU_RESP);
   end

   // Request capture at accept and result capture on response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_q  <= SZ_D;
         off_q   <= 3'b000;
         ext_q   <= 2'b00;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
`ifdef YSYX_22040088_LSU_MISALIGN_EN
         err_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (req_fire) begin
            if (misalign) begin
               done_q  <= 1'b1;
               rdata_q <= '0;
`ifdef YSYX_22040088_LSU_MISALIGN_EN
               err_q   <= 1'b1;
`endif
            end else begin
               size_q  <= decode_size(mem_mask);
               off_q   <= addr[2:0];
               ext_q   <= sel_memdata;
               wen_q   <= mem_wen;
               addr_q  <= {addr[63:3], 3'b000};
               wdata_q <= st_wdata;
               wstrb_q <= st_wstrb;
            end
         end
         if ((state_q == LSU_RESP) && bus_resp_valid) begin
            done_q  <= 1'b1;
            rdata_q <= wen_q ? 64'd0 : ld_data;
`ifdef YSYX_22040088_LSU_MISALIGN_EN
            err_q   <= 1'b0;
`endif
         end
      end
   end

   assign lsu_done  = done_q;
   assign lsu_rdata = rdata_q;
   assign bus_addr  = addr_q;
   assign bus_wen   = wen_q;
   assign bus_wdata = wdata_q;
   assign bus_wstrb = wstrb_q;

endmodule
